// File: rtl/apb_csr_pkg.sv
// Shared types and constants for the APB CSR completer.
package apb_csr_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_csr_state_t;

  localparam int REG_ID       = 0;
  localparam int REG_STATUS   = 1;
  localparam int REG_SCRATCH0 = 2;

  localparam int STATUS_PROTO_ERR_BIT = 31;
  localparam int STATUS_XFER_LSB      = 0;
  localparam int STATUS_XFER_W        = 16;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA9B0_0020;

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable wait-state down-counter; zero_o is high once the count has reached 0.
module apb_wait_ctr #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 4'(WAIT_CYCLES);
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/apb_csr_completer.sv
// APB completer with ID, STATUS and scratch registers plus programmable wait states.
// Optional byte strobes are enabled by defining APB_PSTRB_EN.
module apb_csr_completer
  import apb_csr_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          ADDR_W      = 10,
  parameter int          DATA_W      = 32,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       psel_i,
  input  logic                       penable_i,
  input  logic [ADDR_W-1:0]          paddr_i,
  input  logic                       pwrite_i,
  input  logic [DATA_W-1:0]          pwdata_i,
`ifdef APB_PSTRB_EN
  input  logic [3:0]                 pstrb_i,
`endif
  output logic                       pready_o,
  output logic [DATA_W-1:0]          prdata_o,
  output logic                       pslverr_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int IDX_W       = ADDR_W - 2;
  localparam int NUM_SCRATCH = NUM_REGS - REG_SCRATCH0;

  apb_csr_state_t state_q, state_d;

  logic              latch_w, load_w, dec_w, zero_w, pready_w, proto_set_w;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        strb_q;
  logic [3:0]        strb_in_w;

  logic                       proto_err_q;
  logic [STATUS_XFER_W-1:0]   xfer_count_q;
  logic [DATA_W-1:0]          status_w;
  logic [NUM_REGS*DATA_W-1:0] regs_view_w;
  logic [NUM_REGS*DATA_W-1:0] regs_o_q;

`ifdef APB_PSTRB_EN
  assign strb_in_w = pstrb_i;
`else
  assign strb_in_w = 4'hF;
`endif

  // FSM: next state and per-cycle control strobes
  always_comb begin
    state_d     = state_q;
    latch_w     = 1'b0;
    load_w      = 1'b0;
    dec_w       = 1'b0;
    pready_w    = 1'b0;
    proto_set_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel_i && !penable_i) begin
          latch_w = 1'b1;
          load_w  = 1'b1;
          state_d = ST_ACCESS;
        end else if (psel_i && penable_i) begin
          proto_set_w = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!psel_i) begin
          proto_set_w = 1'b1;
          state_d     = ST_IDLE;
        end else if (penable_i) begin
          if (zero_w) begin
            pready_w = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            dec_w = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      if (latch_w) begin
        addr_q  <= paddr_i;
        write_q <= pwrite_i;
        wdata_q <= pwdata_i;
        strb_q  <= strb_in_w;
      end
    end
  end

  apb_wait_ctr #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_ctr (
    .clk    (clk),
    .reset  (reset),
    .load_i (load_w),
    .dec_i  (dec_w),
    .zero_o (zero_w)
  );

  // Decode runs entirely off the latched access, so bus changes mid-access are ignored.
  logic [IDX_W-1:0] idx_w;
  logic             err_w, commit_w, status_clr_w;

  assign idx_w    = addr_q[ADDR_W-1:2];
  assign err_w    = (addr_q[1:0] != 2'b00)
                  || (32'(idx_w) >= 32'(NUM_REGS))
                  || (write_q && (idx_w == IDX_W'(REG_ID)));
  assign commit_w = pready_w && write_q && !err_w;

  assign status_clr_w = commit_w && (idx_w == IDX_W'(REG_STATUS))
                      && wdata_q[STATUS_PROTO_ERR_BIT] && strb_q[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err_q  <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      if (pready_w) begin
        xfer_count_q <= xfer_count_q + 1'b1;
      end
      if (proto_set_w) begin
        proto_err_q <= 1'b1;
      end else if (status_clr_w) begin
        proto_err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    status_w = '0;
    status_w[STATUS_PROTO_ERR_BIT] = proto_err_q;
    status_w[STATUS_XFER_LSB +: STATUS_XFER_W] = xfer_count_q;
  end

  // Scratch bank: each register owns its flops; read data is OR-folded across hits.
  logic [DATA_W-1:0] rd_fold_w [0:NUM_SCRATCH];
  assign rd_fold_w[0] = '0;

  assign regs_view_w[REG_ID*DATA_W +: DATA_W]     = ID_VALUE;
  assign regs_view_w[REG_STATUS*DATA_W +: DATA_W] = status_w;

  generate
    for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
      logic [DATA_W-1:0] data_q;
      logic              hit_w;

      assign hit_w = (idx_w == IDX_W'(REG_SCRATCH0 + gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q <= '0;
        end else if (commit_w && hit_w) begin
          for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) begin
              data_q[8*b +: 8] <= wdata_q[8*b +: 8];
            end
          end
        end
      end

      assign rd_fold_w[gi+1] = rd_fold_w[gi] | (hit_w ? data_q : '0);
      assign regs_view_w[(REG_SCRATCH0 + gi)*DATA_W +: DATA_W] = data_q;
    end
  endgenerate

  logic [DATA_W-1:0] rdata_w;

  always_comb begin
    rdata_w = '0;
    if (!err_w && !write_q) begin
      if (idx_w == IDX_W'(REG_ID)) begin
        rdata_w = ID_VALUE;
      end else if (idx_w == IDX_W'(REG_STATUS)) begin
        rdata_w = status_w;
      end else begin
        rdata_w = rd_fold_w[NUM_SCRATCH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_o_q <= '0;
    end else begin
      regs_o_q <= regs_view_w;
    end
  end

  assign pready_o  = pready_w;
  assign prdata_o  = pready_w ? rdata_w : '0;
  assign pslverr_o = pready_w && err_w;
  assign regs_o    = regs_o_q;

endmodule
